// File: rtl/rle_compressor.sv
// Streaming run-length encoder: collapses runs of identical symbols into
// (symbol, length) pairs, pulsed on valid_out when the run ends.
module rle_compressor #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  output logic [DATA_W-1:0] data_out,
  output logic [CNT_W-1:0]  count_out,
  output logic              valid_out
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [DATA_W-1:0] cur_sym;
  logic [CNT_W-1:0]  run_cnt;
  logic              run_active;

  logic same_sym, run_full, extend, end_run;

  assign same_sym = (data_in == cur_sym);
  assign run_full = (run_cnt == CNT_MAX);
  assign extend   = run_active && same_sym && !run_full;
  // A saturated run ends exactly like a symbol change; the counter never wraps.
  assign end_run  = run_active && !extend;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_sym    <= '0;
      run_cnt    <= '0;
      run_active <= 1'b0;
      data_out   <= '0;
      count_out  <= '0;
      valid_out  <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      if (valid_in) begin
        if (extend) begin
          run_cnt <= run_cnt + CNT_ONE;
        end else begin
          if (end_run) begin
            data_out  <= cur_sym;
            count_out <= run_cnt;
            valid_out <= 1'b1;
          end
          cur_sym    <= data_in;
          run_cnt    <= CNT_ONE;
          run_active <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_rle_compressor.sv
// Directed + randomized bench for rle_compressor against a queue-based
// model of the pending run.
module tb_rle_compressor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] data_in;
  logic       valid_in;
  logic [7:0] data_out;
  logic [7:0] count_out;
  logic       valid_out;

  int checks = 0;
  int errors = 0;

  // Model: bytes of the pending run, plus the last emitted pair.
  logic [7:0] run_q[$];
  logic       e_vld;
  logic [7:0] e_data;
  int         e_cnt;

  rle_compressor #(.DATA_W(8), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .valid_in(valid_in),
    .data_out(data_out), .count_out(count_out), .valid_out(valid_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    run_q.delete();
    e_vld  = 1'b0;
    e_data = 8'h00;
    e_cnt  = 0;
  endtask

  task automatic model_accept(input logic v, input logic [7:0] d);
    e_vld = 1'b0;
    if (v) begin
      if (run_q.size() != 0 && (d != run_q[0] || run_q.size() == 255)) begin
        e_vld  = 1'b1;
        e_data = run_q[0];
        e_cnt  = run_q.size();
        run_q.delete();
      end
      run_q.push_back(d);
    end
  endtask

  task automatic cmp_model(input string tag);
    chk({tag, ".valid"}, 32'(valid_out), 32'(e_vld));
    chk({tag, ".data"},  32'(data_out),  32'(e_data));
    chk({tag, ".count"}, 32'(count_out), 32'(e_cnt));
  endtask

  task automatic step(input logic v, input logic [7:0] d, input string tag);
    @(negedge clk);
    valid_in = v;
    data_in  = d;
    @(posedge clk);
    model_accept(v, d);
    #1;
    cmp_model(tag);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst_n    = 1'b0;
    valid_in = 1'b0;
    #1;
    model_reset();
    cmp_model(tag);
    @(negedge clk);
    cmp_model(tag);
    rst_n = 1'b1;
  endtask

  task automatic expect_pulse(input string tag, input logic [7:0] d, input int c);
    chk({tag, ".pv"}, 32'(valid_out), 32'd1);
    chk({tag, ".pd"}, 32'(data_out),  32'(d));
    chk({tag, ".pc"}, 32'(count_out), 32'(c));
  endtask

  initial begin
    logic [7:0] seq1 [8];
    logic [7:0] sym;
    int         len;
    seq1 = '{8'h41, 8'h41, 8'h41, 8'h41, 8'h42, 8'h42, 8'h43, 8'h00};
    rst_n    = 1'b0;
    valid_in = 1'b0;
    data_in  = 8'h00;
    model_reset();

    // Reset held 20 ns with idle input.
    #1;  cmp_model("rst0");
    #10; cmp_model("rst1");
    #9;  rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, "idle");

    // Continuous stream, then trailing 00 run stays pending.
    for (int i = 0; i < 8; i++) begin
      step(1'b1, seq1[i], "seq");
      if (i == 4) expect_pulse("seq41", 8'h41, 4);
      if (i == 6) expect_pulse("seq42", 8'h42, 2);
      if (i == 7) expect_pulse("seq43", 8'h43, 1);
    end
    for (int i = 0; i < 10; i++) step(1'b1, 8'h00, "pend00");

    // Run continues across valid_in gaps.
    do_reset("rstg");
    step(1'b1, 8'h41, "gap");
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 8'h99, "gapidle");
      chk("gapidle.v", 32'(valid_out), 32'd0);
    end
    step(1'b1, 8'h41, "gap");
    step(1'b1, 8'h42, "gap");
    expect_pulse("gap41", 8'h41, 2);

    // Saturation at 255.
    do_reset("rsts");
    for (int i = 1; i <= 300; i++) begin
      step(1'b1, 8'h55, "sat");
      if (i == 256) expect_pulse("sat255", 8'h55, 255);
    end
    step(1'b1, 8'hAA, "sat");
    expect_pulse("sat45", 8'h55, 45);

    // Alternating symbols give back-to-back pulses.
    do_reset("rsta");
    step(1'b1, 8'h01, "alt");
    step(1'b1, 8'h02, "alt"); expect_pulse("alt1", 8'h01, 1);
    step(1'b1, 8'h01, "alt"); expect_pulse("alt2", 8'h02, 1);
    step(1'b1, 8'h02, "alt"); expect_pulse("alt3", 8'h01, 1);

    // Reset mid-run drops the pending run.
    do_reset("rstm");
    for (int i = 0; i < 3; i++) step(1'b1, 8'h41, "mid");
    do_reset("rstmid");
    step(1'b1, 8'h42, "mid");
    chk("mid.nov", 32'(valid_out), 32'd0);
    step(1'b1, 8'h43, "mid");
    expect_pulse("mid42", 8'h42, 1);

    // Random runs over a small alphabet with random gaps.
    for (int r = 0; r < 120; r++) begin
      sym = 8'($urandom_range(0, 3));
      len = ($urandom_range(0, 15) == 0) ? int'($urandom_range(200, 300))
                                         : int'($urandom_range(1, 6));
      for (int k = 0; k < len; k++) begin
        if ($urandom_range(0, 3) == 0) step(1'b0, 8'($urandom), "rndgap");
        step(1'b1, sym, "rnd");
      end
      if ($urandom_range(0, 40) == 0) do_reset("rndrst");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
